// File: rtl/adc_capture_buf_pkg.sv
// Shared types for the multi-channel ADC capture buffer.
package adc_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    ARMED,
    CAPTURE,
    READOUT
  } state_t;

  localparam logic MODE_STREAM   = 1'b0;
  localparam logic MODE_SNAPSHOT = 1'b1;

endpackage

// File: rtl/adc_capture_buf_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port.
// The read register holds its value while re_i is low; contents have no reset.
module adc_cap_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/adc_capture_buf.sv
// Multi-channel ADC sample buffer: streaming FIFO or trigger-armed snapshot.
// Optional channel-0 level trigger enabled by defining ADC_CAP_LEVEL_TRIG_EN.
module adc_capture_buf
  import adc_cap_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH_NUM = 2,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned W     = CH_NUM * DATA_W,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [W-1:0]      s_data,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  input  logic              trig,
`ifdef ADC_CAP_LEVEL_TRIG_EN
  input  logic [DATA_W-1:0] trig_level,
`endif
  output logic              m_valid,
  output logic [W-1:0]      m_data,
  input  logic              m_ready,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic              done
);

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d, mem_cnt;
  logic           m_valid_q, m_valid_d, rvalid_q, rvalid_d;
  logic [W-1:0]   m_data_q, m_data_d, ram_rdata;
  logic           overflow_q, overflow_d, done_q, done_d;
  logic [15:0]    drop_q, drop_d;
  logic           pop, load_out, rd_en, wr_en, drop, fire, lvl_fire;

`ifdef ADC_CAP_LEVEL_TRIG_EN
  logic [DATA_W-1:0] prev_ch0_q, prev_ch0_d;
  logic              prev_vld_q, prev_vld_d;

  assign lvl_fire = prev_vld_q
                  && ($signed(prev_ch0_q) < $signed(trig_level))
                  && ($signed(s_data[DATA_W-1:0]) >= $signed(trig_level));
`else
  assign lvl_fire = 1'b0;
`endif

  assign fire = trig | lvl_fire;

  // The RAM read register acts as a one-word skid stage: a fetched word waits
  // there (rvalid_q) until the output register frees up, giving 1 word/clk.
  always_comb begin
    pop      = m_valid_q & m_ready;
    mem_cnt  = level_q - LW'(rvalid_q) - LW'(m_valid_q);
    load_out = rvalid_q & (~m_valid_q | pop) & (state_q != CAPTURE) & ~start;
    rd_en    = ~start & (mem_cnt != '0) & (~rvalid_q | load_out);

    wr_en = 1'b0;
    drop  = 1'b0;
    case (state_q)
      STREAM: begin
        if (s_valid) begin
          if (level_q != LW'(DEPTH) || pop) wr_en = 1'b1;
          else                              drop  = 1'b1;
        end
      end
      ARMED:   wr_en = s_valid & fire;
      CAPTURE: wr_en = s_valid;
      default: ;
    endcase
    wr_en = wr_en & ~start;
    drop  = drop & ~start;

    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(wr_en) - LW'(pop);
    rvalid_d   = rd_en | (rvalid_q & ~load_out);
    m_data_d   = load_out ? ram_rdata : m_data_q;
    m_valid_d  = load_out | (m_valid_q & ~pop);
    overflow_d = overflow_q | drop;
    drop_d     = (drop && drop_q != '1) ? drop_q + 16'd1 : drop_q;

    state_d = state_q;
    case (state_q)
      ARMED:   if (wr_en) state_d = CAPTURE;
      CAPTURE: if (level_d == LW'(DEPTH)) state_d = READOUT;
      READOUT: if (level_d == '0) state_d = IDLE;
      default: ;
    endcase
    if (stop) state_d = IDLE;

`ifdef ADC_CAP_LEVEL_TRIG_EN
    prev_ch0_d = prev_ch0_q;
    prev_vld_d = prev_vld_q;
    if (state_q == ARMED && s_valid) begin
      prev_ch0_d = s_data[DATA_W-1:0];
      prev_vld_d = 1'b1;
    end
    if (start) prev_vld_d = 1'b0;
`endif

    if (start) begin
      state_d    = (mode == MODE_SNAPSHOT) ? ARMED : STREAM;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      rvalid_d   = 1'b0;
      m_valid_d  = 1'b0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end
    done_d = (state_d == READOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rvalid_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rvalid_q   <= rvalid_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      done_q     <= done_d;
    end
  end

`ifdef ADC_CAP_LEVEL_TRIG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ch0_q <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_ch0_q <= prev_ch0_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`endif

  adc_cap_ram #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_data),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
  assign done     = done_q;

endmodule

// File: doc/adc_capture_buf.md
# adc_capture_buf

Parametrised multi-channel ADC sample buffer, the successor to the single-channel free-running ADC ring buffer. It accepts packed CH_NUM-channel sample words on a strobe in the system clock domain and stores them in a DEPTH-entry buffer. It runs either as a streaming FIFO with overflow accounting or as a trigger-armed snapshot recorder, and hands samples to downstream DSP over a valid/ready interface.

## Interface
- DATA_W, 16: bits per channel sample, signed Q1.15 at the default width
- CH_NUM, 2: channels per sample word, 1..8
- DEPTH, 256: buffer entries, power of two, at least 4
- clk in 1: system clock; every port is synchronous to it
- rst_n in 1: reset, asynchronous and active-low
- s_valid in 1: one sample word present this cycle; there is no backpressure
- s_data in CH_NUM*DATA_W: packed sample word, channel 0 in the LSBs
- mode in 1: 0 = stream, 1 = snapshot; sampled only on start
- start in 1: pulse; flushes the buffer and begins operation
- stop in 1: pulse; returns to IDLE without flushing
- trig in 1: external trigger, qualified by s_valid
- m_valid out 1: output word valid
- m_data out CH_NUM*DATA_W: output word
- m_ready in 1: downstream accept
- level out $clog2(DEPTH)+1: samples held, counting the memory and the output register
- overflow out 1: sticky, set when a sample is dropped
- drop_cnt out 16: count of dropped samples, saturating
- done out 1: snapshot is complete (state is READOUT)

## Operation
- States and transitions:
  - IDLE to STREAM on start with mode=0.
  - IDLE to ARMED on start with mode=1.
  - ARMED to CAPTURE on s_valid&trig; that sample is the first one stored.
  - CAPTURE to READOUT when the DEPTH-th sample is stored.
  - READOUT to IDLE when level reaches 0.
  - stop in any state goes to IDLE; start in any state restarts.
- start (including a restart from any state):
  - clears the pointers, level, m_valid, overflow and drop_cnt;
  - latches mode;
  - any s_valid in the start cycle is ignored.
- STREAM:
  - s_valid with level<DEPTH writes the word.
  - s_valid with level==DEPTH and no pop in the same cycle drops the word, sets overflow and increments drop_cnt.
  - Full with a simultaneous pop: the write is accepted and level stays at DEPTH.
- ARMED: samples are discarded, nothing is written, level stays 0.
- CAPTURE: every s_valid is written. m_valid is forced to 0, so no readout happens and no overflow is possible.
- READOUT: s_valid is ignored; the buffer drains through m_valid/m_ready.
- IDLE: s_valid is ignored; any residual contents may still drain.
- Output handshake:
  - A word transfers when m_valid&m_ready are both high.
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer, except on start or reset.
- Pointers wrap modulo DEPTH. level is updated as +1 per write and -1 per pop, both in the same cycle.

## Timing
- Reset values: m_valid=0, m_data=0, level=0, overflow=0, drop_cnt=0, done=0, state IDLE, pointers 0.
- Latency: a word written on edge k, into an empty buffer with an empty output register, gives m_valid=1 after edge k+2. This is one cycle for the RAM write and one for the registered read.
- Sustained throughput is 1 word per clk with m_ready held high.
- level, overflow and drop_cnt are registered and update on the edge after the event.
- done is asserted the cycle after the DEPTH-th capture write.
- Reset asserted mid-operation forces the reset values immediately. Buffer contents are undefined afterwards.

## Configuration
- ADC_CAP_LEVEL_TRIG_EN defined:
  - Adds input trig_level[DATA_W-1:0], signed.
  - In ARMED the trigger also fires on a rising crossing of channel 0: previous ch0 < trig_level and current ch0 >= trig_level, compared as signed.
  - The previous-sample register is invalidated on start, so at least one ARMED sample must precede a level trigger.
  - This trigger is ORed with trig.
- Not defined: the trig_level port is absent and only trig triggers.

## Structure
- Package adc_cap_pkg holds:
  - the state enum (IDLE, STREAM, ARMED, CAPTURE, READOUT);
  - the mode constants MODE_STREAM=0 and MODE_SNAPSHOT=1.
- Sub-module adc_cap_ram is a simple dual-port RAM, DEPTH x CH_NUM*DATA_W, with a synchronous read and no reset on its contents.

## Test plan
- Stream, CH_NUM=2, m_ready=1: words 0x0001_8000..0x0010_8000 on consecutive cycles. Each appears 2 cycles after its write, in order, and overflow stays 0.
- Stream, m_ready=0, 260 strobes into DEPTH=256: level saturates at 256, overflow=1, drop_cnt=4, and the first 256 words read back unchanged.
- Full buffer, s_valid together with a pop: the write is accepted, level stays 256 and drop_cnt does not increment.
- Snapshot, start then 10 untriggered samples then trig: level stays 0 until the trigger, done after 256 captures, and the first output equals the trigger sample.
- With ADC_CAP_LEVEL_TRIG_EN and trig_level=0x0000: ch0 sequence 0xFFF0, 0x0010 triggers on 0x0010. Starting directly at 0x0010 does not trigger.
- Reset pulsed mid-CAPTURE: all outputs return to their reset values immediately and state is IDLE.
